// File: rtl/led_ctrl_seq.sv
// led_ctrl_seq: autonomous LED pattern sequencer feeding the blinking-LED driver
//   clk      system clock
//   resetn   asynchronous active-low reset
//   wr_en    register write strobe, one cycle per write
//   wr_addr  register write address (0 CTRL, 1 STATUS, 2..5 PAT, 6..9 DWELL)
//   wr_data  register write data
//   rd_addr  register read address
//   rd_data  registered read data, one cycle latency
//   control  LED control word presented to the driver
//   step     index of the active pattern slot
//   busy     high while stepping through slots
module led_ctrl_seq #(
  parameter int          NSTEP    = 4,
  parameter logic [31:0] RST_WORD = 32'h803d0900
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] control,
  output logic [1:0]  step,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]  state, state_nxt, step_nxt, ridx;
  logic [3:0]  ctrl;
  logic [31:0] cnt, cnt_nxt, dw, ctl_nxt, rd_val;
  logic [31:0] pat [NSTEP];
  logic [31:0] dwell [NSTEP];
  logic [31:0] pat_nxt [NSTEP];
  logic        ctrl_wr, step_end, is_last;
  assign busy = state == RUN;
  assign ridx = rd_addr[1:0] - 2'd2;
  always_comb begin
    ctrl_wr = wr_en && wr_addr == 4'd0;
    dw = dwell[step];
    // slot timing always uses the pre-write dwell/last values of this cycle
    step_end = state == RUN && dw != 32'd0 && cnt >= dw - 32'd1;
    is_last = step >= ctrl[3:2];
    // forward a same-cycle PAT write so control shows it right after the write edge
    for (int i = 0; i < NSTEP; i++)
      pat_nxt[i] = (wr_en && wr_addr == 4'(i + 2)) ? wr_data : pat[i];
    state_nxt = state;
    step_nxt = step;
    cnt_nxt = cnt;
    if (ctrl_wr) begin
      state_nxt = wr_data[0] ? RUN : IDLE;
      step_nxt = 2'd0;
      cnt_nxt = 32'd0;
    end else if (step_end) begin
      cnt_nxt = 32'd0;
      state_nxt = (is_last && ctrl[1]) ? DONE : RUN;
      step_nxt = !is_last ? step + 2'd1 : ctrl[1] ? ctrl[3:2] : 2'd0;
    end else if (state == RUN) begin
      // saturate so an indefinite hold never wraps into a spurious advance
      cnt_nxt = cnt + 32'(cnt != '1);
    end
    ctl_nxt = state_nxt == IDLE ? RST_WORD : pat_nxt[step_nxt];
    rd_val = rd_addr == 4'd0 ? {28'd0, ctrl} :
             rd_addr == 4'd1 ? {28'd0, state == DONE, busy, step} :
             rd_addr < 4'd6  ? pat[ridx] :
             rd_addr < 4'd10 ? dwell[ridx] : 32'd0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      step <= 2'd0;
      cnt <= 32'd0;
      ctrl <= 4'd0;
      control <= RST_WORD;
      rd_data <= 32'd0;
      for (int i = 0; i < NSTEP; i++) begin
        pat[i] <= 32'd0;
        dwell[i] <= 32'd0;
      end
    end else begin
      state <= state_nxt;
      step <= step_nxt;
      cnt <= cnt_nxt;
      control <= ctl_nxt;
      rd_data <= rd_val;
      if (ctrl_wr) ctrl <= wr_data[3:0];
      for (int i = 0; i < NSTEP; i++) begin
        pat[i] <= pat_nxt[i];
        if (wr_en && wr_addr == 4'(i + 6)) dwell[i] <= wr_data;
      end
    end
  end
endmodule

// File: tb/tb_led_ctrl_seq.sv
// tb_led_ctrl_seq: vector table, directed corner sequences and randomized model check for led_ctrl_seq
module tb_led_ctrl_seq;
  localparam logic [31:0] RST_WORD = 32'h803d0900;
  logic        clk = 1'b0, resetn = 1'b0, wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0, rd_addr = 4'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data, control;
  logic [1:0]  step;
  logic        busy;
  int tests = 0, failed = 0;

  led_ctrl_seq dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .control(control), .step(step), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra;
    logic [31:0] ctl;
    logic [1:0]  st;
    logic        bsy;
    logic [31:0] rd;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic wen, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ra,
                     input logic [31:0] ctl, input logic [1:0] st, input logic bsy, input logic [31:0] rd);
    vec_t v;
    v.wen = wen; v.wa = wa; v.wd = wd; v.ra = ra; v.ctl = ctl; v.st = st; v.bsy = bsy; v.rd = rd;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // reference model: slot shown for a number of cycles, ends once shown >= its dwell
  int          m_mode, m_slot;
  longint      m_shown;
  logic [3:0]  m_ctrl;
  logic [31:0] m_pat [4];
  logic [31:0] m_dw [4];
  logic [31:0] e_ctl, e_rd;
  logic [1:0]  e_st;
  logic        e_bsy;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a == 0) return {28'd0, m_ctrl};
    if (a == 1) return {28'd0, m_mode == 2, m_mode == 1, 2'(m_slot)};
    if (a >= 2 && a <= 5) return m_pat[a - 2];
    if (a >= 6 && a <= 9) return m_dw[a - 6];
    return 32'd0;
  endfunction

  task automatic model_step(input logic wen, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ra);
    int last;
    last = int'(m_ctrl[3:2]);
    e_rd = m_read(ra);
    if (m_mode == 1) begin
      if (m_dw[m_slot] != 0 && m_shown >= longint'(m_dw[m_slot])) begin
        m_shown = 1;
        if (m_slot < last) m_slot++;
        else if (m_ctrl[1]) begin m_mode = 2; m_slot = last; end
        else m_slot = 0;
      end else m_shown++;
    end
    if (wen) begin
      if (wa == 0) begin
        m_ctrl = wd[3:0]; m_mode = wd[0] ? 1 : 0; m_slot = 0; m_shown = 1;
      end else if (wa >= 2 && wa <= 5) m_pat[wa - 2] = wd;
      else if (wa >= 6 && wa <= 9) m_dw[wa - 6] = wd;
    end
    e_ctl = m_mode == 0 ? RST_WORD : m_pat[m_slot];
    e_st = 2'(m_slot);
    e_bsy = m_mode == 1;
  endtask

  initial begin
    logic [31:0] lp [4];
    int prev;
    int seg_s [5];
    int seg_n [5];
    lp[0] = 32'hC0000000; lp[1] = 32'h00000000; lp[2] = 32'h40000100; lp[3] = 32'hC0000000;
    seg_s[0] = 0; seg_s[1] = 1; seg_s[2] = 2; seg_s[3] = 3; seg_s[4] = 0;
    seg_n[0] = 4; seg_n[1] = 3; seg_n[2] = 4; seg_n[3] = 2; seg_n[4] = 1;
    for (int i = 0; i < 4; i++) add(1, 4'(i + 2), lp[i], 4'(i + 2), RST_WORD, 0, 0, 0);
    add(1, 6, 5, 6, RST_WORD, 0, 0, 0);
    add(1, 7, 3, 7, RST_WORD, 0, 0, 0);
    add(1, 8, 4, 8, RST_WORD, 0, 0, 0);
    add(1, 9, 2, 9, RST_WORD, 0, 0, 0);
    add(1, 0, 32'h0D, 2, lp[0], 0, 1, lp[0]);
    prev = 0;
    for (int s = 0; s < 5; s++)
      for (int k = 0; k < seg_n[s]; k++) begin
        add(0, 0, 0, 1, lp[seg_s[s]], 2'(seg_s[s]), 1, 32'(4 + prev));
        prev = seg_s[s];
      end
    add(1, 4'hF, 32'hFFFFFFFF, 4'hF, lp[0], 0, 1, 0);
    add(0, 0, 0, 0, lp[0], 0, 1, 32'h0D);

    #12;
    chk("reset_control", control, RST_WORD);
    chk("reset_step", 32'(step), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rd", rd_data, 0);
    resetn = 1'b1;

    foreach (tv[i]) begin
      wr_en = tv[i].wen; wr_addr = tv[i].wa; wr_data = tv[i].wd; rd_addr = tv[i].ra;
      tick();
      chk($sformatf("vec%0d_control", i), control, tv[i].ctl);
      chk($sformatf("vec%0d_step", i), 32'(step), 32'(tv[i].st));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].bsy));
      chk($sformatf("vec%0d_rd", i), rd_data, tv[i].rd);
    end
    wr_en = 1'b0; rd_addr = 4'hF;

    wr(0, 32'h0);
    chk("disable_control", control, RST_WORD);
    chk("disable_busy", 32'(busy), 0);
    wr(0, 32'h0D);
    chk("restart_control", control, 32'hC0000000);
    chk("restart_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("restart_hold0", 32'(step), 0);
    end
    tick();
    chk("restart_step1", 32'(step), 1);
    chk("restart_pat1", control, 32'h0);

    wr(0, 32'h0);
    wr(3, 32'h40000200);
    wr(6, 2);
    wr(7, 3);
    wr(0, 32'h07);
    chk("oneshot_start", 32'(step), 0);
    tick(); chk("oneshot_s0", 32'(step), 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("oneshot_s1", 32'(step), 1); chk("oneshot_s1_busy", 32'(busy), 1);
    end
    tick();
    chk("oneshot_done_busy", 32'(busy), 0);
    chk("oneshot_done_step", 32'(step), 1);
    chk("oneshot_done_control", control, 32'h40000200);
    rd_addr = 1;
    tick();
    chk("oneshot_status", rd_data, 32'h9);
    rd_addr = 4'hF;
    repeat (3) tick();
    chk("oneshot_hold_control", control, 32'h40000200);

    wr(0, 32'h0);
    wr(7, 0);
    wr(8, 40);
    wr(9, 20);
    wr(0, 32'h0D);
    tick();
    tick();
    chk("hold_enter", 32'(step), 1);
    for (int i = 0; i < 1000; i++) begin
      tick();
      chk("hold_step1", 32'(step), 1);
    end
    wr(7, 1);
    chk("hold_write_edge", 32'(step), 1);
    tick();
    chk("hold_release", 32'(step), 2);
    repeat (10) tick();
    wr(8, 4);
    chk("live_dwell_edge", 32'(step), 2);
    tick();
    chk("live_dwell_adv", 32'(step), 3);
    wr(5, 32'hC0000123);
    chk("live_pat_control", control, 32'hC0000123);
    repeat (18) tick();
    chk("live_pat_nocntreset", 32'(step), 3);
    tick();
    chk("live_wrap", 32'(step), 0);
    chk("live_wrap_control", control, 32'hC0000000);

    #3 resetn = 1'b0;
    #1;
    chk("async_rst_control", control, RST_WORD);
    chk("async_rst_step", 32'(step), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_rd", rd_data, 0);
    #2 resetn = 1'b1;
    for (int a = 0; a < 16; a++) begin
      if (a > 9 && a != 15) continue;
      rd_addr = 4'(a);
      tick();
      chk($sformatf("rst_read%0d", a), rd_data, 0);
    end

    m_mode = 0; m_slot = 0; m_shown = 0; m_ctrl = 0;
    for (int i = 0; i < 4; i++) begin m_pat[i] = 0; m_dw[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      wr_en = r < 30;
      wr_addr = r < 3 ? 4'd0 : r < 4 ? 4'hF : r < 5 ? 4'd1 : 4'($urandom_range(2, 9));
      wr_data = $urandom;
      if (wr_addr == 0) wr_data = {28'd0, 4'($urandom_range(0, 15)) | 4'(r != 1)};
      if (wr_addr >= 6 && wr_addr <= 9) wr_data = 32'($urandom_range(0, 12) == 0 ? 0 : $urandom_range(1, 6));
      rd_addr = 4'($urandom_range(0, 15));
      model_step(wr_en, wr_addr, wr_data, rd_addr);
      tick();
      chk("rand_control", control, e_ctl);
      chk("rand_step", 32'(step), 32'(e_st));
      chk("rand_busy", 32'(busy), 32'(e_bsy));
      chk("rand_rd", rd_data, e_rd);
    end
    wr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
